univ_rotate_reg: RTL and testbench

Parameterised universal rotate register with a 2-bit mode control. On each rising clock edge it parallel-loads, rotates left, rotates right or holds its contents. It is a general-purpose datapath building block used wherever a circular shift of a small word is needed, such as pattern generators, ring counters and bit-serial alignment. The output is the register state itself; there is no combinational path from inputs to output.

---
 rtl/univ_rotate_reg.sv | 43 ++++
 tb/tb_univ_rotate_reg.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/univ_rotate_reg.sv
// Universal rotate register: parallel load, rotate left/right or hold per clock.
// q is the register itself; the wrap-around bit is the only shift source.
module univ_rotate_reg #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          async_rst,
    input  logic [1:0]    ctrl,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] q
);

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_ROR  = 2'b01,
        MODE_ROL  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    mode_t         mode;
    logic [DW-1:0] q_next;

    assign mode = mode_t'(ctrl);

    always_comb begin
        q_next = q;
        unique case (mode)
            MODE_LOAD: q_next = data;
            MODE_ROR:  q_next = {q[0], q[DW-1:1]};
            MODE_ROL:  q_next = {q[DW-2:0], q[DW-1]};
            MODE_HOLD: q_next = q;
        endcase
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: tb/tb_univ_rotate_reg.sv
// Bench for univ_rotate_reg (DW = 4): a reference model feeds a scoreboard queue
// at drive time; each result is popped and compared after the following clock edge.
module tb_univ_rotate_reg;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          async_rst = 1'b1;
    logic [1:0]    ctrl = 2'b00;
    logic [DW-1:0] data = '0;
    logic [DW-1:0] q;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] model = '0;

    univ_rotate_reg #(.DW(DW)) dut (
        .clk       (clk),
        .async_rst (async_rst),
        .ctrl      (ctrl),
        .data      (data),
        .q         (q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one operation, predict it, wait one edge, compare against the
    // scoreboard and against the literal value the scenario calls for.
    task automatic step(input logic [1:0] c, input logic [DW-1:0] d,
                        input string tag, input logic [DW-1:0] plan);
        logic [DW-1:0] exp_v;
        ctrl = c;
        data = d;
        if (!async_rst) begin
            model = '0;
        end else begin
            case (c)
                2'b00:   model = d;
                2'b10:   model = {model[DW-2:0], model[DW-1]};
                2'b01:   model = {model[0], model[DW-1:1]};
                default: model = model;
            endcase
        end
        sb_q.push_back(model);
        #3;
        if (c != 2'b00) data = DW'($urandom_range(0, (1 << DW) - 1));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, q, 'x);
        end else begin
            exp_v = sb_q.pop_front();
            chk(tag, q, exp_v);
        end
        chk({tag, "_plan"}, q, plan);
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        async_rst = 1'b0;
        #1;
        chk(tag, q, 4'b0000);
        model = '0;
        #1;
        async_rst = 1'b1;
    endtask

    initial begin
        // Reset asserted between edges clears q immediately
        #2;
        async_rst = 1'b0;
        #1;
        chk("rst_immediate", q, 4'b0000);
        step(2'b00, 4'hA, "rst_hold0", 4'b0000);
        step(2'b00, 4'hA, "rst_hold1", 4'b0000);
        async_rst = 1'b1;

        // Load and rotate left with hold
        step(2'b00, 4'b1001, "rol_load", 4'b1001);
        step(2'b10, 4'h0, "rol1", 4'b0011);
        step(2'b10, 4'h0, "rol2", 4'b0110);
        step(2'b11, 4'hF, "rol_hold1", 4'b0110);
        step(2'b11, 4'h5, "rol_hold2", 4'b0110);
        step(2'b10, 4'h0, "rol3", 4'b1100);
        step(2'b10, 4'h0, "rol4", 4'b1001);

        // Load and rotate right with hold
        step(2'b00, 4'b1001, "ror_load", 4'b1001);
        step(2'b01, 4'h0, "ror1", 4'b1100);
        step(2'b01, 4'h0, "ror2", 4'b0110);
        step(2'b11, 4'hA, "ror_hold1", 4'b0110);
        step(2'b11, 4'h3, "ror_hold2", 4'b0110);
        step(2'b01, 4'h0, "ror3", 4'b0011);
        step(2'b01, 4'h0, "ror4", 4'b1001);

        // Full wrap both directions
        step(2'b00, 4'b0001, "wrap_load", 4'b0001);
        step(2'b10, 4'h0, "wrap_l1", 4'b0010);
        step(2'b10, 4'h0, "wrap_l2", 4'b0100);
        step(2'b10, 4'h0, "wrap_l3", 4'b1000);
        step(2'b10, 4'h0, "wrap_l4", 4'b0001);
        step(2'b01, 4'h0, "wrap_r1", 4'b1000);
        step(2'b01, 4'h0, "wrap_r2", 4'b0100);
        step(2'b01, 4'h0, "wrap_r3", 4'b0010);
        step(2'b01, 4'h0, "wrap_r4", 4'b0001);

        // Mixed sequence with random data in non-load modes
        step(2'b00, 4'b1011, "mix_load", 4'b1011);
        step(2'b10, DW'($urandom_range(0, 15)), "mix_rol", 4'b0111);
        step(2'b01, DW'($urandom_range(0, 15)), "mix_ror", 4'b1011);
        step(2'b11, DW'($urandom_range(0, 15)), "mix_hold", 4'b1011);
        step(2'b01, DW'($urandom_range(0, 15)), "mix_ror2", 4'b1101);

        // Reset mid-rotate, then resume from zero
        step(2'b00, 4'b1001, "mid_load", 4'b1001);
        step(2'b10, 4'h0, "mid_rol1", 4'b0011);
        step(2'b10, 4'h0, "mid_rol2", 4'b0110);
        pulse_reset("mid_rst");
        step(2'b10, 4'h0, "post_rst_rol", 4'b0000);
        step(2'b00, 4'b0101, "post_rst_load", 4'b0101);

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1);
    end
endmodule
